// File: rtl/iq_frame_sequencer_if.sv
// iq_frame_sequencer_if: AXI-Stream link from the IQ frame sequencer toward the Welch engine.
interface iq_frame_sequencer_if;
    logic [63:0] m_tdata;
    logic        m_tvalid;
    logic        m_tlast;
    logic        m_tready;
    modport master (output m_tdata, m_tvalid, m_tlast, input m_tready);
    modport slave  (input m_tdata, m_tvalid, m_tlast, output m_tready);
endinterface

// File: rtl/iq_frame_sequencer.sv
// iq_frame_sequencer: double-buffers IQ frames into two RAM banks and replays complete,
// correctly sized frames over AXI-Stream in completion order.
module iq_frame_sequencer #(
    parameter int DEPTH = 512
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 in_frame_start,
    input  logic                 in_frame_end,
    input  logic [63:0]          in_data,
    input  logic                 in_valid,
    input  logic [10:0]          cfg_frame_words,
    iq_frame_sequencer_if.master m,
    output logic                 frame_error,
    output logic [15:0]          frames_dropped
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [10:0] DW = 11'(DEPTH);
    typedef enum logic [1:0] {FREE, FILL, FULL, READ} bank_t;
    typedef enum logic [1:0] {W_IDLE, W_FILL, W_DROP} wstate_t;
    typedef enum logic [1:0] {R_IDLE, R_PREFETCH, R_STREAM} rstate_t;
    bank_t       bst [2];
    logic [3:0]  seq [2];
    logic [10:0] blen [2];
    logic [63:0] mem [2*DEPTH];
    wstate_t     wstate;
    rstate_t     rstate;
    logic        wbank, rbank, ovr;
    logic [10:0] len, wcount, raddr, cnt_eff;
    logic [3:0]  wseq, age;
    logic        inc, wr_en, ovr_eff, closing, good, bad, pick, any_free, any_full, rsel;
    logic [1:0]  free_after;
    always_comb begin
        inc        = wstate == W_FILL && in_valid && wcount < len;
        wr_en      = inc && wcount < DW;
        cnt_eff    = wcount + 11'(inc);
        ovr_eff    = ovr || (wstate == W_FILL && in_valid && wcount >= len);
        closing    = wstate == W_FILL && (in_frame_end || in_frame_start);
        good       = closing && in_frame_end && cnt_eff == len && !ovr_eff && len != 11'd0 && len <= DW;
        bad        = closing && !good;
        // a bank discarded this cycle may be re-used by a coincident frame start
        free_after = {bst[1] == FREE || (bad && wbank), bst[0] == FREE || (bad && !wbank)};
        any_free   = |free_after;
        pick       = !free_after[0];
        age        = seq[1] - seq[0];
        any_full   = bst[0] == FULL || bst[1] == FULL;
        rsel       = (bst[0] == FULL && bst[1] == FULL) ? age[3] : bst[1] == FULL;
    end
    always_ff @(posedge clk)
        if (wr_en) mem[{wbank, wcount[AW-1:0]}] <= in_data;
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            bst[0]         <= FREE;
            bst[1]         <= FREE;
            seq[0]         <= '0;
            seq[1]         <= '0;
            blen[0]        <= '0;
            blen[1]        <= '0;
            wstate         <= W_IDLE;
            rstate         <= R_IDLE;
            wbank          <= 1'b0;
            rbank          <= 1'b0;
            ovr            <= 1'b0;
            len            <= '0;
            wcount         <= '0;
            raddr          <= '0;
            wseq           <= '0;
            frame_error    <= 1'b0;
            frames_dropped <= '0;
            m.m_tdata      <= '0;
            m.m_tvalid     <= 1'b0;
            m.m_tlast      <= 1'b0;
        end else begin
            frame_error <= bad;
            if (rstate == R_IDLE && any_full) begin
                bst[rsel] <= READ;
                rbank     <= rsel;
                rstate    <= R_PREFETCH;
            end else if (rstate == R_PREFETCH) begin
                raddr  <= '0;
                rstate <= R_STREAM;
            end else if (rstate == R_STREAM && (!m.m_tvalid || m.m_tready)) begin
                if (m.m_tvalid && m.m_tlast) begin
                    m.m_tvalid <= 1'b0;
                    m.m_tlast  <= 1'b0;
                    bst[rbank] <= FREE;
                    rstate     <= R_IDLE;
                end else begin
                    m.m_tdata  <= mem[{rbank, raddr[AW-1:0]}];
                    m.m_tvalid <= 1'b1;
                    m.m_tlast  <= raddr == blen[rbank] - 11'd1;
                    raddr      <= raddr + 11'd1;
                end
            end
            if (good) begin
                bst[wbank]  <= FULL;
                seq[wbank]  <= wseq;
                blen[wbank] <= len;
                wseq        <= wseq + 4'd1;
            end else if (bad) bst[wbank] <= FREE;
            if (in_frame_start) begin
                if (any_free) begin
                    bst[pick] <= FILL;
                    wbank     <= pick;
                    len       <= cfg_frame_words;
                    wcount    <= '0;
                    ovr       <= 1'b0;
                    wstate    <= W_FILL;
                end else begin
                    wstate <= W_DROP;
                    if (frames_dropped != 16'hFFFF) frames_dropped <= frames_dropped + 16'd1;
                end
            end else if (closing || (wstate == W_DROP && in_frame_end)) wstate <= W_IDLE;
            else if (wstate == W_FILL) begin
                wcount <= cnt_eff;
                ovr    <= ovr_eff;
            end
        end
    end
endmodule

// File: doc/iq_frame_sequencer.md
IQ_FRAME_SEQUENCER -- requirements
Module: iq_frame_sequencer

Interface
REQ-001 The block SHALL have parameter DEPTH, default 512, meaning words per bank (power of two, 2..1024).
REQ-002 The block SHALL have port clk  input  1  sole clock; all logic on its rising edge.
REQ-003 The block SHALL have port resetn  input  1  reset, asynchronous and active-low.
REQ-004 The block SHALL have port in_frame_start  input  1  one-cycle pulse, an IQ frame begins.
REQ-005 The block SHALL have port in_frame_end  input  1  one-cycle pulse, the current IQ frame has ended.
REQ-006 The block SHALL have port in_data  input  64  IQ payload word.
REQ-007 The block SHALL have port in_valid  input  1  in_data qualifier, no backpressure.
REQ-008 The block SHALL have port cfg_frame_words  input  11  expected payload words per frame.
REQ-009 The block SHALL have port m_tdata  output  64  AXI-Stream payload toward the Welch engine.
REQ-010 The block SHALL have port m_tvalid  output  1  stream valid.
REQ-011 The block SHALL have port m_tlast  output  1  last word of a frame.
REQ-012 The block SHALL have port m_tready  input  1  stream ready.
REQ-013 The block SHALL have port frame_error  output  1  one-cycle pulse, frame discarded for length or abort.
REQ-014 The block SHALL have port frames_dropped  output  16  saturating count of frames rejected because no bank was free.

Function
REQ-015 Storage SHALL be two banks (0, 1) of DEPTH x 64 bits, each in state FREE, FILL, FULL or READ.
REQ-016 Write FSM states SHALL be W_IDLE, W_FILL, W_DROP.
- W_IDLE + in_frame_start with a FREE bank: pick bank 0 if both are free, else the free one.
- Then latch cfg_frame_words into len, clear wcount and go to W_FILL.
REQ-017 W_IDLE + in_frame_start with no FREE bank SHALL go to W_DROP and increment frames_dropped, saturating at 0xFFFF.
REQ-018 In W_FILL, each in_valid cycle SHALL write in_data at address wcount, then increment wcount.
- When wcount >= len, the write is suppressed and an overrun flag is set.
REQ-019 In W_FILL, in_frame_end SHALL close the frame.
- If wcount == len and there was no overrun: bank becomes FULL, tagged with a completion sequence number, next state W_IDLE.
- Otherwise: bank becomes FREE, frame_error pulses next cycle, next state W_IDLE.
REQ-020 In W_FILL, in_frame_start without in_frame_end SHALL abort the current frame (bank FREE, frame_error pulse) and be handled as in W_IDLE in the same cycle.
REQ-021 If in_frame_end and in_frame_start coincide, the block SHALL close the current frame first, then apply in_frame_start.
REQ-022 W_DROP SHALL ignore in_valid and return to W_IDLE on in_frame_end, or re-evaluate immediately on in_frame_start.
REQ-023 A len value of 0 or greater than DEPTH SHALL make every frame end with frame_error.
REQ-024 Read FSM states SHALL be R_IDLE, R_PREFETCH, R_STREAM.
- R_IDLE with any FULL bank: select the oldest FULL bank by sequence number, mark it READ, go to R_PREFETCH.
REQ-025 R_PREFETCH SHALL issue a read of address 0 and enter R_STREAM with m_tvalid high one cycle later.
- Total latency: in_frame_end sampled at edge k gives m_tvalid high after edge k+3 when the reader is idle.
REQ-026 m_tdata and m_tlast SHALL remain stable while m_tvalid=1 and m_tready=0, and m_tvalid SHALL NOT drop without a handshake.
REQ-027 Each handshake SHALL advance the read address, sustaining one word per cycle while m_tready=1.
- m_tlast=1 exactly on word len-1 of the bank's latched length.
REQ-028 On the m_tlast handshake the bank SHALL become FREE in the next cycle.
- If another bank is FULL, the next frame's m_tvalid follows after the prefetch cycle.
REQ-029 Frames SHALL be output in completion order, never interleaved, never partially.
REQ-030 A bank freed by the reader SHALL be selectable by an in_frame_start in the same cycle it becomes FREE.

Reset
REQ-031 While resetn=0, outputs SHALL be: m_tvalid=0, m_tlast=0, m_tdata=0, frame_error=0, frames_dropped=0; both banks FREE, FSMs W_IDLE/R_IDLE.
REQ-032 Reset asserted mid-frame or mid-stream SHALL discard all stored frames without emitting any further beats; RAM contents need not be cleared.

Verification
REQ-033 cfg=4, one frame of words 1..4 with m_tready=1 -> m_tvalid at k+3, data 1,2,3,4, m_tlast on 4, no frame_error.
REQ-034 cfg=4, frame of 3 words, then a frame of 5 words -> two frame_error pulses, no m_tvalid.
REQ-035 m_tready=0, three back-to-back good frames -> frames_dropped=1; after m_tready=1, frames 1 and 2 are output in order.
REQ-036 m_tready toggled 1010 during a stream -> every word output exactly once, stable while stalled.
REQ-037 in_frame_start at word 2 of a cfg=4 frame, followed by a good frame -> one frame_error, only the second frame is output.
REQ-038 resetn pulsed low during an m_tvalid stall -> all outputs 0, banks FREE, next good frame is output normally.
